// File: rtl/lockin_run_sequencer.sv
// lockin_run_sequencer
// Run controller for one lock-in measurement through the coherent averager
// and segmented lock-in chain. The controller:
//   - holds the chain in reset (LOAD) so it latches its runtime parameters,
//   - waits for the chain to report ready_to_calculate (ARM),
//   - enables the chain and pairs phase/quadrature results (RUN),
//   - reports done / error / result count to the HPS register interface.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   start, abort            one-cycle requests from the HPS
//   timeout_limit           max idle cycles in ARM/RUN (0 disables)
//   n_results               result pairs to collect (0 treated as 1), sampled on start
//   proc_reset_n            to the chain's reset_n
//   proc_enable             to the chain's enable_gral
//   ready_to_calculate      chain is ready to start
//   processing_finished     chain has no more results
//   data_out1(_valid)       phase result from the chain
//   data_out2(_valid)       quadrature result from the chain
//   result_fase/cuad        last completed pair
//   result_valid            one-cycle pulse per completed pair
//   result_count            completed pairs in the current run
//   busy, done, error       status flags; state is the encoded FSM state
// All outputs are registered.

module lockin_run_sequencer #(
  parameter int RESET_CYCLES = 4,
  parameter int TO_W         = 24,
  parameter int DATA_W       = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [TO_W-1:0]   timeout_limit,
  input  logic [15:0]       n_results,
  output logic              proc_reset_n,
  output logic              proc_enable,
  input  logic              ready_to_calculate,
  input  logic              processing_finished,
  input  logic [DATA_W-1:0] data_out1,
  input  logic              data_out1_valid,
  input  logic [DATA_W-1:0] data_out2,
  input  logic              data_out2_valid,
  output logic [DATA_W-1:0] result_fase,
  output logic [DATA_W-1:0] result_cuad,
  output logic              result_valid,
  output logic [15:0]       result_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [15:0]       n_lat_q, n_lat_d;
  logic [15:0]       count_q, count_d;
  logic              fase_pend_q, fase_pend_d;
  logic              cuad_pend_q, cuad_pend_d;
  logic [DATA_W-1:0] fase_sh_q, fase_sh_d;
  logic [DATA_W-1:0] cuad_sh_q, cuad_sh_d;
  logic [DATA_W-1:0] res_fase_q, res_fase_d;
  logic [DATA_W-1:0] res_cuad_q, res_cuad_d;
  logic              res_valid_q, res_valid_d;
  logic              proc_reset_n_q, proc_reset_n_d;
  logic              proc_enable_q, proc_enable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              pair;
  logic              timed_out;

  // A pair completes when each channel is either pending or valid right now.
  assign pair = (state_q == S_RUN) &&
                (fase_pend_q || data_out1_valid) &&
                (cuad_pend_q || data_out2_valid);

  // cnt_q holds the idle cycles already elapsed, so the limit is reached in
  // the cycle where the count including the current one equals the limit.
  // This keeps ARM/RUN idle for exactly timeout_limit cycles before ERROR.
  assign timed_out = (timeout_limit != '0) && ((cnt_q + TO_W'(1)) == timeout_limit);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_lat_d     = n_lat_q;
    count_d     = count_q;
    fase_pend_d = fase_pend_q;
    cuad_pend_d = cuad_pend_q;
    fase_sh_d   = fase_sh_q;
    cuad_sh_d   = cuad_sh_q;
    res_fase_d  = res_fase_q;
    res_cuad_d  = res_cuad_q;
    res_valid_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_LOAD;
          n_lat_d     = (n_results == 16'd0) ? 16'd1 : n_results;
          count_d     = 16'd0;
          fase_pend_d = 1'b0;
          cuad_pend_d = 1'b0;
          // The shared counter counts down through LOAD.
          cnt_d       = TO_W'(RESET_CYCLES - 1);
        end
      end
      S_LOAD: begin
        if (cnt_q == '0) begin
          state_d = S_ARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - TO_W'(1);
        end
      end
      S_ARM: begin
        if (ready_to_calculate) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_RUN: begin
        // A repeated valid before the partner arrives just overwrites the shadow.
        if (data_out1_valid) fase_sh_d = data_out1;
        if (data_out2_valid) cuad_sh_d = data_out2;
        if (pair) begin
          res_fase_d  = data_out1_valid ? data_out1 : fase_sh_q;
          res_cuad_d  = data_out2_valid ? data_out2 : cuad_sh_q;
          res_valid_d = 1'b1;
          count_d     = count_q + 16'd1;
          fase_pend_d = 1'b0;
          cuad_pend_d = 1'b0;
          cnt_d       = '0;
        end else begin
          if (data_out1_valid) fase_pend_d = 1'b1;
          if (data_out2_valid) cuad_pend_d = 1'b1;
          cnt_d = cnt_q + TO_W'(1);
        end
        // A pair completing in the timeout cycle clears the idle count and wins.
        if (processing_finished || (pair && (count_d == n_lat_q))) begin
          state_d = S_DONE;
        end else if (!pair && timed_out) begin
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides start, timeout and completion; results and count are held.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      count_d     = count_q;
      res_fase_d  = res_fase_q;
      res_cuad_d  = res_cuad_q;
      res_valid_d = 1'b0;
      fase_pend_d = 1'b0;
      cuad_pend_d = 1'b0;
    end

    // Status outputs are decoded from the next state so they are registered.
    proc_reset_n_d = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DONE);
    proc_enable_d  = (state_d == S_RUN);
    busy_d         = (state_d == S_LOAD) || (state_d == S_ARM) || (state_d == S_RUN);
    done_d         = (state_d == S_DONE);
    error_d        = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      n_lat_q        <= 16'd1;
      count_q        <= 16'd0;
      fase_pend_q    <= 1'b0;
      cuad_pend_q    <= 1'b0;
      fase_sh_q      <= '0;
      cuad_sh_q      <= '0;
      res_fase_q     <= '0;
      res_cuad_q     <= '0;
      res_valid_q    <= 1'b0;
      proc_reset_n_q <= 1'b0;
      proc_enable_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      n_lat_q        <= n_lat_d;
      count_q        <= count_d;
      fase_pend_q    <= fase_pend_d;
      cuad_pend_q    <= cuad_pend_d;
      fase_sh_q      <= fase_sh_d;
      cuad_sh_q      <= cuad_sh_d;
      res_fase_q     <= res_fase_d;
      res_cuad_q     <= res_cuad_d;
      res_valid_q    <= res_valid_d;
      proc_reset_n_q <= proc_reset_n_d;
      proc_enable_q  <= proc_enable_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign state        = state_q;
  assign proc_reset_n = proc_reset_n_q;
  assign proc_enable  = proc_enable_q;
  assign result_fase  = res_fase_q;
  assign result_cuad  = res_cuad_q;
  assign result_valid = res_valid_q;
  assign result_count = count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_lockin_run_sequencer.sv
// tb_lockin_run_sequencer
// Table-driven bench for lockin_run_sequencer: each table row is one clock
// cycle of inputs plus the registered outputs expected after that edge.
// Hand-written sequences cover timeout, pair-beats-timeout and async reset.

module tb_lockin_run_sequencer;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] ARM  = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;

  typedef struct packed {
    logic [2:0]  st;
    logic        prn;
    logic        pen;
    logic        rv;
    logic [15:0] rc;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] fase;
    logic [63:0] cuad;
  } exp_t;

  typedef struct {
    logic        start;
    logic        abort;
    logic        ready;
    logic        fin;
    logic        v1;
    logic [63:0] d1;
    logic        v2;
    logic [63:0] d2;
    logic [15:0] n;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [23:0] timeout_limit;
  logic [15:0] n_results;
  logic        proc_reset_n;
  logic        proc_enable;
  logic        ready_to_calculate;
  logic        processing_finished;
  logic [63:0] data_out1;
  logic        data_out1_valid;
  logic [63:0] data_out2;
  logic        data_out2_valid;
  logic [63:0] result_fase;
  logic [63:0] result_cuad;
  logic        result_valid;
  logic [15:0] result_count;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  state;

  int testsRun = 0;
  int testsFailed = 0;

  lockin_run_sequencer #(.RESET_CYCLES(4), .TO_W(24), .DATA_W(64)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .abort               (abort),
    .timeout_limit       (timeout_limit),
    .n_results           (n_results),
    .proc_reset_n        (proc_reset_n),
    .proc_enable         (proc_enable),
    .ready_to_calculate  (ready_to_calculate),
    .processing_finished (processing_finished),
    .data_out1           (data_out1),
    .data_out1_valid     (data_out1_valid),
    .data_out2           (data_out2),
    .data_out2_valid     (data_out2_valid),
    .result_fase         (result_fase),
    .result_cuad         (result_cuad),
    .result_valid        (result_valid),
    .result_count        (result_count),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .state               (state)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected status flags follow from the expected state.
  function automatic exp_t mkExp(input logic [2:0] st, input logic prn, input logic pen,
                                 input logic rv, input logic [15:0] rc,
                                 input logic [63:0] f, input logic [63:0] c);
    exp_t e;
    e.st   = st;
    e.prn  = prn;
    e.pen  = pen;
    e.rv   = rv;
    e.rc   = rc;
    e.busy = (st == LOAD) || (st == ARM) || (st == RUN);
    e.done = (st == DONE);
    e.err  = (st == ERR);
    e.fase = f;
    e.cuad = c;
    return e;
  endfunction

  function automatic vec_t V(input logic s, input logic ab, input logic rdy, input logic fin,
                             input logic v1, input logic [63:0] d1,
                             input logic v2, input logic [63:0] d2, input logic [15:0] n,
                             input logic [2:0] st, input logic prn, input logic pen,
                             input logic rv, input logic [15:0] rc,
                             input logic [63:0] f, input logic [63:0] c);
    vec_t v;
    v.start = s;
    v.abort = ab;
    v.ready = rdy;
    v.fin   = fin;
    v.v1    = v1;
    v.d1    = d1;
    v.v2    = v2;
    v.d2    = d2;
    v.n     = n;
    v.e     = mkExp(st, prn, pen, rv, rc, f, c);
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, then sample 1 unit past the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    start               = v.start;
    abort               = v.abort;
    ready_to_calculate  = v.ready;
    processing_finished = v.fin;
    data_out1_valid     = v.v1;
    data_out1           = v.d1;
    data_out2_valid     = v.v2;
    data_out2           = v.d2;
    n_results           = v.n;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t got;
    got.st   = state;
    got.prn  = proc_reset_n;
    got.pen  = proc_enable;
    got.rv   = result_valid;
    got.rc   = result_count;
    got.busy = busy;
    got.done = done;
    got.err  = error;
    got.fase = result_fase;
    got.cuad = result_cuad;
    testsRun++;
    if (got !== e) begin
      testsFailed++;
      $display("[TB] FAIL %s: got st=%0d rstn=%b en=%b rv=%b cnt=%0d busy=%b done=%b err=%b f=%h c=%h | expected st=%0d rstn=%b en=%b rv=%b cnt=%0d busy=%b done=%b err=%b f=%h c=%h",
               name, got.st, got.prn, got.pen, got.rv, got.rc, got.busy, got.done, got.err, got.fase, got.cuad,
               e.st, e.prn, e.pen, e.rv, e.rc, e.busy, e.done, e.err, e.fase, e.cuad);
    end
  endtask

  // Idle cycle helper used by the hand-written sequences.
  function automatic vec_t idleVec();
    return V(0,0,0,0, 0,64'h0, 0,64'h0, 16'd5, IDLE,0,0,0,16'd0,64'h0,64'h0);
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   armCycles;

    reset               = 1'b1;
    start               = 1'b0;
    abort               = 1'b0;
    timeout_limit       = 24'd0;
    n_results           = 16'd0;
    ready_to_calculate  = 1'b0;
    processing_finished = 1'b0;
    data_out1           = 64'h0;
    data_out1_valid     = 1'b0;
    data_out2           = 64'h0;
    data_out2_valid     = 1'b0;

    //          s ab rdy fin v1 d1     v2 d2     n      | st   prn pen rv rc     fase    cuad
    // Full run: n=2, two simultaneous pairs.
    tbl.push_back(V(1,0,0,0, 0,64'h0,  0,64'h0,  16'd2, LOAD,0,0,0,16'd0,64'h0, 64'h0));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd2, LOAD,0,0,0,16'd0,64'h0, 64'h0));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd2, LOAD,0,0,0,16'd0,64'h0, 64'h0));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd2, LOAD,0,0,0,16'd0,64'h0, 64'h0));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd2, ARM, 1,0,0,16'd0,64'h0, 64'h0));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd2, ARM, 1,0,0,16'd0,64'h0, 64'h0));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd2, ARM, 1,0,0,16'd0,64'h0, 64'h0));
    tbl.push_back(V(0,0,1,0, 0,64'h0,  0,64'h0,  16'd2, RUN, 1,1,0,16'd0,64'h0, 64'h0));
    tbl.push_back(V(0,0,0,0, 1,64'h11, 1,64'h22, 16'd2, RUN, 1,1,1,16'd1,64'h11,64'h22));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd2, RUN, 1,1,0,16'd1,64'h11,64'h22));
    tbl.push_back(V(0,0,0,0, 1,64'h33, 1,64'h44, 16'd2, DONE,1,0,1,16'd2,64'h33,64'h44));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd2, DONE,1,0,0,16'd2,64'h33,64'h44));
    // Restart from DONE, n=1: fase A, fase B, then cuad C.
    tbl.push_back(V(1,0,0,0, 0,64'h0,  0,64'h0,  16'd1, LOAD,0,0,0,16'd0,64'h33,64'h44));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd1, LOAD,0,0,0,16'd0,64'h33,64'h44));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd1, LOAD,0,0,0,16'd0,64'h33,64'h44));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd1, LOAD,0,0,0,16'd0,64'h33,64'h44));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd1, ARM, 1,0,0,16'd0,64'h33,64'h44));
    tbl.push_back(V(0,0,1,0, 0,64'h0,  0,64'h0,  16'd1, RUN, 1,1,0,16'd0,64'h33,64'h44));
    tbl.push_back(V(0,0,0,0, 1,64'hA,  0,64'h0,  16'd1, RUN, 1,1,0,16'd0,64'h33,64'h44));
    tbl.push_back(V(0,0,0,0, 1,64'hB,  0,64'h0,  16'd1, RUN, 1,1,0,16'd0,64'h33,64'h44));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  1,64'hC,  16'd1, DONE,1,0,1,16'd1,64'hB, 64'hC));
    // n=5, one pair, then abort together with start.
    tbl.push_back(V(1,0,0,0, 0,64'h0,  0,64'h0,  16'd5, LOAD,0,0,0,16'd0,64'hB, 64'hC));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd5, LOAD,0,0,0,16'd0,64'hB, 64'hC));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd5, LOAD,0,0,0,16'd0,64'hB, 64'hC));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd5, LOAD,0,0,0,16'd0,64'hB, 64'hC));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd5, ARM, 1,0,0,16'd0,64'hB, 64'hC));
    tbl.push_back(V(0,0,1,0, 0,64'h0,  0,64'h0,  16'd5, RUN, 1,1,0,16'd0,64'hB, 64'hC));
    tbl.push_back(V(0,0,0,0, 1,64'h55, 1,64'h66, 16'd5, RUN, 1,1,1,16'd1,64'h55,64'h66));
    tbl.push_back(V(1,1,0,0, 0,64'h0,  0,64'h0,  16'd5, IDLE,0,0,0,16'd1,64'h55,64'h66));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd5, IDLE,0,0,0,16'd1,64'h55,64'h66));
    // Start while busy is ignored; processing_finished after 1 of 5 pairs.
    tbl.push_back(V(1,0,0,0, 0,64'h0,  0,64'h0,  16'd5, LOAD,0,0,0,16'd0,64'h55,64'h66));
    tbl.push_back(V(1,0,0,0, 0,64'h0,  0,64'h0,  16'd5, LOAD,0,0,0,16'd0,64'h55,64'h66));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd5, LOAD,0,0,0,16'd0,64'h55,64'h66));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd5, LOAD,0,0,0,16'd0,64'h55,64'h66));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd5, ARM, 1,0,0,16'd0,64'h55,64'h66));
    tbl.push_back(V(0,0,1,0, 0,64'h0,  0,64'h0,  16'd5, RUN, 1,1,0,16'd0,64'h55,64'h66));
    tbl.push_back(V(0,0,0,0, 1,64'h77, 1,64'h88, 16'd5, RUN, 1,1,1,16'd1,64'h77,64'h88));
    tbl.push_back(V(0,0,0,1, 0,64'h0,  0,64'h0,  16'd5, DONE,1,0,0,16'd1,64'h77,64'h88));
    // n=0 behaves as n=1.
    tbl.push_back(V(1,0,0,0, 0,64'h0,  0,64'h0,  16'd0, LOAD,0,0,0,16'd0,64'h77,64'h88));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd0, LOAD,0,0,0,16'd0,64'h77,64'h88));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd0, LOAD,0,0,0,16'd0,64'h77,64'h88));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd0, LOAD,0,0,0,16'd0,64'h77,64'h88));
    tbl.push_back(V(0,0,0,0, 0,64'h0,  0,64'h0,  16'd0, ARM, 1,0,0,16'd0,64'h77,64'h88));
    tbl.push_back(V(0,0,1,0, 0,64'h0,  0,64'h0,  16'd0, RUN, 1,1,0,16'd0,64'h77,64'h88));
    tbl.push_back(V(0,0,0,0, 1,64'h12, 1,64'h34, 16'd0, DONE,1,0,1,16'd1,64'h12,64'h34));

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_values", mkExp(IDLE,0,0,0,16'd0,64'h0,64'h0));
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("row%0d", i), tbl[i].e);
    end

    // Timeout in ARM: limit 10, ready never arrives.
    timeout_limit = 24'd10;
    v = idleVec();
    v.start = 1'b1;
    applyStimulus(v);
    armCycles = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(idleVec());
      if (state == ARM) armCycles++;
      else if (armCycles > 0) break;
    end
    testsRun++;
    if (armCycles != 10) begin
      testsFailed++;
      $display("[TB] FAIL arm_timeout_cycles: got %0d expected 10", armCycles);
    end
    checkOutput("timeout_error", mkExp(ERR,0,0,0,16'd0,64'h12,64'h34));

    // A pair in the timeout cycle beats the timeout; limit 3.
    timeout_limit = 24'd3;
    v = idleVec();
    v.start = 1'b1;
    applyStimulus(v);
    for (int k = 0; k < 4; k++) applyStimulus(idleVec());
    checkOutput("pt_arm", mkExp(ARM,1,0,0,16'd0,64'h12,64'h34));
    v = idleVec();
    v.ready = 1'b1;
    applyStimulus(v);
    applyStimulus(idleVec());
    applyStimulus(idleVec());
    checkOutput("pt_run_idle2", mkExp(RUN,1,1,0,16'd0,64'h12,64'h34));
    v = idleVec();
    v.v1 = 1'b1;  v.d1 = 64'hF1;
    v.v2 = 1'b1;  v.d2 = 64'hF2;
    applyStimulus(v);
    checkOutput("pt_pair_wins", mkExp(RUN,1,1,1,16'd1,64'hF1,64'hF2));
    applyStimulus(idleVec());
    checkOutput("pt_idle1", mkExp(RUN,1,1,0,16'd1,64'hF1,64'hF2));
    applyStimulus(idleVec());
    checkOutput("pt_idle2", mkExp(RUN,1,1,0,16'd1,64'hF1,64'hF2));
    applyStimulus(idleVec());
    checkOutput("pt_timeout", mkExp(ERR,0,0,0,16'd1,64'hF1,64'hF2));

    // Asynchronous reset in the middle of a RUN cycle.
    timeout_limit = 24'd0;
    v = idleVec();
    v.start = 1'b1;
    applyStimulus(v);
    for (int k = 0; k < 4; k++) applyStimulus(idleVec());
    v = idleVec();
    v.ready = 1'b1;
    applyStimulus(v);
    v = idleVec();
    v.v1 = 1'b1;  v.d1 = 64'h5A;
    v.v2 = 1'b1;  v.d2 = 64'hA5;
    applyStimulus(v);
    checkOutput("pre_reset_run", mkExp(RUN,1,1,1,16'd1,64'h5A,64'hA5));
    @(negedge clk);
    start           = 1'b0;
    data_out1_valid = 1'b0;
    data_out2_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_mid_run", mkExp(IDLE,0,0,0,16'd0,64'h0,64'h0));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/lockin_run_sequencer.md
Name: lockin_run_sequencer

Overview:
- Run controller that sequences one lock-in measurement through the signal-processing chain (coherent averager plus segmented lock-in).
- Drives the chain's active-low reset_n, which latches the runtime parameters, and its enable_gral.
- Waits for ready_to_calculate, pairs the phase/quadrature results, and reports done, error and result count to the HPS register interface.
- Sits between the HPS control registers and the processing block.

Parameters:
- RESET_CYCLES, 4, cycles proc_reset_n is held low in LOAD so the parameter registers latch (minimum 2).
- TO_W, 24, width of the timeout counter and timeout_limit.
- DATA_W, 64, width of the result words.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle run request from HPS
- abort  in  1  one-cycle abort request from HPS
- timeout_limit  in  TO_W  maximum idle cycles in ARM/RUN; 0 disables the timeout
- n_results  in  16  result pairs to collect; 0 is treated as 1; sampled on start
- proc_reset_n  out  1  to the processing chain's reset_n
- proc_enable  out  1  to the processing chain's enable_gral
- ready_to_calculate  in  1  from the processing chain
- processing_finished  in  1  from the processing chain
- data_out1  in  DATA_W  phase result
- data_out1_valid  in  1  phase result valid
- data_out2  in  DATA_W  quadrature result
- data_out2_valid  in  1  quadrature result valid
- result_fase  out  DATA_W  last completed phase value
- result_cuad  out  DATA_W  last completed quadrature value
- result_valid  out  1  one-cycle pulse per completed pair
- result_count  out  16  completed pairs in the current run
- busy  out  1  high in LOAD, ARM, RUN
- done  out  1  high in DONE
- error  out  1  high in ERROR
- state  out  3  encoded state for debug

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, proc_reset_n = 0, proc_enable = 0.
  - result_fase, result_cuad, result_count, result_valid, busy, done, error all 0.
- State encoding: IDLE=0, LOAD=1, ARM=2, RUN=3, DONE=4, ERROR=5. All outputs are registered.
- IDLE:
  - proc_reset_n = 0, proc_enable = 0.
  - start -> LOAD: latch n_results (0 becomes 1), clear result_count and the pending flags, load the cycle counter.
- LOAD:
  - proc_reset_n = 0 for exactly RESET_CYCLES cycles, then -> ARM.
  - proc_reset_n rises on the first ARM cycle.
- ARM:
  - proc_reset_n = 1, proc_enable = 0.
  - ready_to_calculate sampled high -> RUN; proc_enable = 1 from the next cycle.
- RUN, pairing rules:
  - Separate sticky pending flags for fase and cuad.
  - A valid captures its data into a shadow register and sets its flag. A repeated valid on one channel before the other arrives overwrites the shadow; the flag stays set.
  - Both valid in the same cycle completes a pair in that cycle.
  - On pair completion (registered, 1-cycle latency): copy the shadows to result_fase/result_cuad, pulse result_valid, increment result_count, clear both flags.
- RUN, exit conditions:
  - result_count reaches the latched n_results -> DONE.
  - processing_finished high -> DONE after any pair completing that same cycle is counted.
- DONE:
  - proc_enable = 0, proc_reset_n stays 1 so the chain keeps its state.
  - done = 1; result registers are held.
- ERROR:
  - proc_enable = 0, proc_reset_n = 0, error = 1; result registers are held.
- Restart and start handling:
  - start in DONE or ERROR clears done/error and -> LOAD.
  - start in LOAD, ARM or RUN is ignored.
- Timeout:
  - The counter clears on entry to ARM and RUN and on every completed pair; it increments each cycle otherwise.
  - timeout_limit != 0 and counter == timeout_limit -> ERROR.
  - A pair completing in the timeout cycle wins: the counter clears and there is no error.
- Abort:
  - abort in any state other than IDLE -> IDLE next cycle, with proc_enable = 0, proc_reset_n = 0, done = error = 0.
  - result_count is held until the next start.
  - abort has priority over start, timeout and completion.
- Counter width: result_count does not wrap because RUN exits at n_results <= 65535.

Test Plan:
- Reset mid-RUN -> all outputs return to reset values immediately, asynchronously; proc_reset_n = 0.
- start, RESET_CYCLES=4, ready high 3 cycles after ARM, n_results=2, two simultaneous valid pairs (0x11/0x22, 0x33/0x44) -> proc_reset_n low exactly 4 cycles; two result_valid pulses; result_fase = 0x33, result_cuad = 0x44; result_count = 2; done.
- RUN, fase valid with 0xA, fase valid with 0xB, then cuad valid with 0xC -> a single pulse with fase = 0xB, cuad = 0xC; result_count = 1.
- timeout_limit=10, ready never asserted -> ERROR on the 10th ARM cycle; error = 1; proc_reset_n = 0; proc_enable = 0.
- n_results=0 -> run ends after one pair. processing_finished asserted after 1 of 5 pairs -> DONE with result_count = 1.
- abort and start in the same RUN cycle -> IDLE, busy = 0, start ignored. start while busy -> ignored, no re-LOAD.
